control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Multi-cycle control unit directly upstream of `datapath`. Produces every control field `datapath` consumes (`NS`, `SA`, `SB`, `DA`, `WR`, `FS`, `C0`, `reset`, `PCSEL`, `PS`, enables, `MW`, `MR`, `BSEL`, `ROM_EN`) plus the constant `K`.
- Decodes `IR_OUT` and branches on `status`, replacing the hand-written control words currently driven by the bench.
- Moore machine: outputs decode from the state register and `IR_OUT`.

Parameters:
- DATA_WIDTH, 16, width of `IR_OUT` and `K`.
- OPC_HALT, 4'hF, opcode that enters HALT.

Ports:
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `IR_OUT` in 16: instruction register from `datapath`. Fields: [15:12] opcode, [11:8] DA, [7:4] SA, [3:0] SB, [7:0] imm8.
- `status` in 4: {V,C,N,Z} from `datapath`.
- `NS` out 3: current state code.
- `SA`, `SB`, `DA` out 4 each: register selects.
- `WR` out 1: register-file write.
- `FS` out 5: ALU function.
- `C0` out 1: ALU carry-in.
- `DP_RESET` out 1: active-high reset to `datapath`.
- `PCSEL` out 1: 1 = PC offset source is `K`.
- `PS` out 2: PC op. 00 hold, 01 +1, 10 +K, 11 load from bus.
- `EN_ALU`, `ENADDRESS_ALU`, `IR_EN`, `ENADDRESS_PC`, `EN_PC` out 1 each: bus/load enables.
- `MW`, `MR` out 1 each: memory write/read.
- `BSEL` out 1: B operand = `K`.
- `ROM_EN` out 1: instruction ROM read.
- `K` out 16: constant.
- `ILLEGAL` out 1: pulses in DECODE on an unassigned opcode.

Behaviour:
- States (`NS` code):
  - RST 000
  - FETCH 001
  - DECODE 010
  - EXEC 011
  - MEM1 100
  - MEM2 101
  - HALT 111
- While `reset`=0: state = RST; all outputs 0 except `DP_RESET`=1.
- First edge after `reset` rises: RST→FETCH, `DP_RESET` drops to 0. RST lasts exactly one cycle after release.
- FETCH: `ROM_EN`=`ENADDRESS_PC`=`IR_EN`=1. `IR_OUT` is valid in DECODE. Next state DECODE.
- DECODE: all enables 0, `WR`/`MW`=0. Transitions on opcode:
  - 0..5, 8..A → EXEC
  - 6, 7 → MEM1
  - OPC_HALT → HALT
  - other → FETCH, with `ILLEGAL`=1 and `PS`=01, `EN_PC`=1 (skip).
- Defaults in every state unless listed: outputs 0; `SA`/`SB`/`DA` = IR fields; `PCSEL`=0; `K`=0.
- FS codes: PASSA 00000, ADD 00010, SUB 00101, AND 01100, OR 01101, PASSB 01000.
- EXEC by opcode. Every EXEC asserts `EN_PC`=1 and `PS`=01 unless stated; next state FETCH.
  - 0 NOP: PC+1 only.
  - 1 ADD: `WR`=1, `EN_ALU`=1, FS=ADD, `C0`=0.
  - 2 SUB: FS=SUB, `C0`=1, otherwise as ADD.
  - 3 AND: FS=AND, otherwise as ADD.
  - 4 OR: FS=OR, otherwise as ADD.
  - 5 LDI: `K`=zero-ext imm8, `BSEL`=1, FS=PASSB, `WR`=1, `EN_ALU`=1.
  - 8 BZ: if `status`[0]=1 then `PS`=10, `PCSEL`=1, `K`=sign-ext imm8; else `PS`=01.
  - 9 BNZ: same as BZ with the condition inverted.
  - A JMP: FS=PASSA, `EN_ALU`=1, `PS`=11 (PC←R[SA]).
- `status` is sampled combinationally in EXEC, i.e. the flags left by the previous instruction.
- MEM1: FS=PASSA, `EN_ALU`=1, `ENADDRESS_ALU`=1 (address = R[SA]).
  - LD (6): `MR`=1 → MEM2.
  - ST (7): `MW`=1 for exactly this cycle, data = R[SB], `PS`=01, `EN_PC`=1 → FETCH.
- MEM2 (LD only): `MR`=1, `ENADDRESS_ALU`=1, `WR`=1 to R[DA], `PS`=01, `EN_PC`=1 → FETCH.
- Cycle counts: ALU/LDI/branch/JMP/ST = 3 cycles; LD = 4 cycles.
- HALT: all outputs 0, `NS`=111; held until `reset`=0.
- `MW` and `WR` are never asserted in the same cycle. `MW` and `MR` are never both 1.
- `reset` asserted mid-instruction (including in MEM1 during ST): state → RST immediately and asynchronously; `MW`/`WR` drop in the same cycle. No partial write completes after the reset assertion.
- `K` sign-extension: bit 7 of imm8 replicated to [15:8]. imm8=8'hFC → `K`=16'hFFFC.

Test Plan:
- Reset: hold `reset`=0 for 3 cycles, release → `DP_RESET`=1 only until the first edge; `NS` sequence 000, 001, 010.
- ADD: `IR_OUT`=16'h1312 → in EXEC `DA`=3, `SA`=1, `SB`=2, FS=00010, `WR`=1, `PS`=01; back to FETCH after 3 cycles. SUB 16'h2312 → FS=00101, `C0`=1.
- LDI: `IR_OUT`=16'h540C → `K`=16'h000C, `BSEL`=1, FS=01000, `WR`=1, `DA`=4.
- LD then ST: 16'h6350 → `MR`=1 in MEM1 and MEM2, `WR`=1 only in MEM2 (4 cycles). 16'h7056 → `MW`=1 for one cycle only, `WR`=0 throughout.
- Branch: BZ 16'h80FC with `status`=4'b0001 → `PS`=10, `PCSEL`=1, `K`=16'hFFFC. With `status`=0 → `PS`=01. Opcode C → `ILLEGAL` pulse, next state FETCH.
- Halt/reset: 16'hF000 → `NS`=111 held for 10 cycles. Assert `reset` during MEM1 of ST → `MW` falls the same cycle, `NS`=000.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Control-word bundle between control_sequencer and datapath.
// The master side drives control fields; the slave side returns IR_OUT and status.
interface control_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] IR_OUT;
    logic [3:0]            status;
    logic [2:0]            NS;
    logic [3:0]            SA;
    logic [3:0]            SB;
    logic [3:0]            DA;
    logic                  WR;
    logic [4:0]            FS;
    logic                  C0;
    logic                  DP_RESET;
    logic                  PCSEL;
    logic [1:0]            PS;
    logic                  EN_ALU;
    logic                  ENADDRESS_ALU;
    logic                  IR_EN;
    logic                  ENADDRESS_PC;
    logic                  EN_PC;
    logic                  MW;
    logic                  MR;
    logic                  BSEL;
    logic                  ROM_EN;
    logic [DATA_WIDTH-1:0] K;
    logic                  ILLEGAL;

    modport master (
        input  IR_OUT, status,
        output NS, SA, SB, DA, WR, FS, C0, DP_RESET, PCSEL, PS,
               EN_ALU, ENADDRESS_ALU, IR_EN, ENADDRESS_PC, EN_PC,
               MW, MR, BSEL, ROM_EN, K, ILLEGAL
    );

    modport slave (
        output IR_OUT, status,
        input  NS, SA, SB, DA, WR, FS, C0, DP_RESET, PCSEL, PS,
               EN_ALU, ENADDRESS_ALU, IR_EN, ENADDRESS_PC, EN_PC,
               MW, MR, BSEL, ROM_EN, K, ILLEGAL
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle Moore control unit for datapath: fetch, decode, execute/memory,
// with control fields decoded from the state register and IR_OUT.
module control_sequencer #(
    parameter int         DATA_WIDTH = 16,
    parameter logic [3:0] OPC_HALT   = 4'hF
) (
    input  logic                clock,
    input  logic                reset,
    control_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_RST    = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_EXEC   = 3'b011,
        S_MEM1   = 3'b100,
        S_MEM2   = 3'b101,
        S_HALT   = 3'b111
    } state_t;

    localparam logic [4:0] FS_PASSA = 5'b00000;
    localparam logic [4:0] FS_ADD   = 5'b00010;
    localparam logic [4:0] FS_SUB   = 5'b00101;
    localparam logic [4:0] FS_AND   = 5'b01100;
    localparam logic [4:0] FS_OR    = 5'b01101;
    localparam logic [4:0] FS_PASSB = 5'b01000;

    state_t                state, next_state;
    logic [3:0]            opc;
    logic [7:0]            imm8;
    logic [DATA_WIDTH-1:0] k_zext, k_sext;
    logic                  unused_status;

    assign opc           = bus.IR_OUT[15:12];
    assign imm8          = bus.IR_OUT[7:0];
    assign k_zext        = {{(DATA_WIDTH-8){1'b0}}, imm8};
    assign k_sext        = {{(DATA_WIDTH-8){imm8[7]}}, imm8};
    assign unused_status = &{1'b0, bus.status[3:1]};

    // NOTE: async reset forces RST at once, so an in-flight MW/WR drops in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_RST;
        else        state <= next_state;
    end

    // NOTE: every output gets a default before the case, so no path leaves one unassigned (no latches).
    always_comb begin
        next_state        = state;
        bus.NS            = state;
        bus.SA            = bus.IR_OUT[7:4];
        bus.SB            = bus.IR_OUT[3:0];
        bus.DA            = bus.IR_OUT[11:8];
        bus.WR            = 1'b0;
        bus.FS            = FS_PASSA;
        bus.C0            = 1'b0;
        bus.DP_RESET      = 1'b0;
        bus.PCSEL         = 1'b0;
        bus.PS            = 2'b00;
        bus.EN_ALU        = 1'b0;
        bus.ENADDRESS_ALU = 1'b0;
        bus.IR_EN         = 1'b0;
        bus.ENADDRESS_PC  = 1'b0;
        bus.EN_PC         = 1'b0;
        bus.MW            = 1'b0;
        bus.MR            = 1'b0;
        bus.BSEL          = 1'b0;
        bus.ROM_EN        = 1'b0;
        bus.K             = '0;
        bus.ILLEGAL       = 1'b0;

        case (state)
            S_RST: begin
                bus.SA       = 4'h0;
                bus.SB       = 4'h0;
                bus.DA       = 4'h0;
                bus.DP_RESET = 1'b1;
                next_state   = S_FETCH;
            end
            S_FETCH: begin
                bus.ROM_EN       = 1'b1;
                bus.ENADDRESS_PC = 1'b1;
                bus.IR_EN        = 1'b1;
                next_state       = S_DECODE;
            end
            S_DECODE: begin
                if (opc == OPC_HALT) begin
                    next_state = S_HALT;
                end else begin
                    case (opc)
                        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                        4'h8, 4'h9, 4'hA: next_state = S_EXEC;
                        4'h6, 4'h7:       next_state = S_MEM1;
                        default: begin
                            // Unassigned opcode: flag it and step over the word.
                            bus.ILLEGAL = 1'b1;
                            bus.PS      = 2'b01;
                            bus.EN_PC   = 1'b1;
                            next_state  = S_FETCH;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                bus.EN_PC  = 1'b1;
                bus.PS     = 2'b01;
                next_state = S_FETCH;
                case (opc)
                    4'h1: begin bus.WR = 1'b1; bus.EN_ALU = 1'b1; bus.FS = FS_ADD; end
                    4'h2: begin bus.WR = 1'b1; bus.EN_ALU = 1'b1; bus.FS = FS_SUB; bus.C0 = 1'b1; end
                    4'h3: begin bus.WR = 1'b1; bus.EN_ALU = 1'b1; bus.FS = FS_AND; end
                    4'h4: begin bus.WR = 1'b1; bus.EN_ALU = 1'b1; bus.FS = FS_OR;  end
                    4'h5: begin
                        bus.WR     = 1'b1;
                        bus.EN_ALU = 1'b1;
                        bus.FS     = FS_PASSB;
                        bus.BSEL   = 1'b1;
                        bus.K      = k_zext;
                    end
                    4'h8, 4'h9: begin
                        // Z flag comes from the previous instruction; opcode bit 0 inverts the test.
                        if (bus.status[0] ^ opc[0]) begin
                            bus.PS    = 2'b10;
                            bus.PCSEL = 1'b1;
                            bus.K     = k_sext;
                        end
                    end
                    4'hA: begin
                        bus.FS     = FS_PASSA;
                        bus.EN_ALU = 1'b1;
                        bus.PS     = 2'b11;
                    end
                    default: ;
                endcase
            end
            S_MEM1: begin
                bus.FS            = FS_PASSA;
                bus.EN_ALU        = 1'b1;
                bus.ENADDRESS_ALU = 1'b1;
                if (opc == 4'h6) begin
                    bus.MR     = 1'b1;
                    next_state = S_MEM2;
                end else begin
                    bus.MW     = 1'b1;
                    bus.PS     = 2'b01;
                    bus.EN_PC  = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_MEM2: begin
                bus.MR            = 1'b1;
                bus.ENADDRESS_ALU = 1'b1;
                bus.WR            = 1'b1;
                bus.PS            = 2'b01;
                bus.EN_PC         = 1'b1;
                next_state        = S_FETCH;
            end
            S_HALT: begin
                bus.SA     = 4'h0;
                bus.SB     = 4'h0;
                bus.DA     = 4'h0;
                next_state = S_HALT;
            end
            default: begin
                bus.SA     = 4'h0;
                bus.SB     = 4'h0;
                bus.DA     = 4'h0;
                next_state = S_RST;
            end
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks reset, ALU, LDI, LD/ST, branch,
// illegal, halt and mid-store reset with hand-computed control words.
module tb_control_sequencer;
    logic clock;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    control_sequencer_if #(.DATA_WIDTH(16)) bus ();

    control_sequencer #(.DATA_WIDTH(16), .OPC_HALT(4'hF)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        bus.IR_OUT = 16'h1312;
        bus.status = 4'b0000;

        // Reset held for three cycles
        repeat (3) tick();
        check("rst_ns", 32'(bus.NS), 32'h0);
        check("rst_dp_reset", 32'(bus.DP_RESET), 32'h1);
        check("rst_sa_zero", 32'(bus.SA), 32'h0);
        check("rst_da_zero", 32'(bus.DA), 32'h0);
        check("rst_rom_en", 32'(bus.ROM_EN), 32'h0);
        check("rst_wr", 32'(bus.WR), 32'h0);

        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rel_ns_rst", 32'(bus.NS), 32'h0);
        check("rel_dp_reset", 32'(bus.DP_RESET), 32'h1);
        tick();
        check("fetch_ns", 32'(bus.NS), 32'h1);
        check("fetch_dp_reset", 32'(bus.DP_RESET), 32'h0);
        check("fetch_rom_en", 32'(bus.ROM_EN), 32'h1);
        check("fetch_ir_en", 32'(bus.IR_EN), 32'h1);
        check("fetch_enaddr_pc", 32'(bus.ENADDRESS_PC), 32'h1);

        // ADD 1312
        tick();
        check("add_decode_ns", 32'(bus.NS), 32'h2);
        check("add_decode_wr", 32'(bus.WR), 32'h0);
        check("add_decode_en_pc", 32'(bus.EN_PC), 32'h0);
        tick();
        check("add_exec_ns", 32'(bus.NS), 32'h3);
        check("add_da", 32'(bus.DA), 32'h3);
        check("add_sa", 32'(bus.SA), 32'h1);
        check("add_sb", 32'(bus.SB), 32'h2);
        check("add_fs", 32'(bus.FS), 32'h02);
        check("add_wr", 32'(bus.WR), 32'h1);
        check("add_ps", 32'(bus.PS), 32'h1);
        check("add_en_pc", 32'(bus.EN_PC), 32'h1);
        check("add_c0", 32'(bus.C0), 32'h0);
        check("add_en_alu", 32'(bus.EN_ALU), 32'h1);
        tick();
        check("add_back_fetch", 32'(bus.NS), 32'h1);

        // SUB 2312
        bus.IR_OUT = 16'h2312;
        tick();
        tick();
        check("sub_exec_ns", 32'(bus.NS), 32'h3);
        check("sub_fs", 32'(bus.FS), 32'h05);
        check("sub_c0", 32'(bus.C0), 32'h1);
        check("sub_wr", 32'(bus.WR), 32'h1);
        tick();

        // LDI 540C
        bus.IR_OUT = 16'h540C;
        tick();
        tick();
        check("ldi_k", 32'(bus.K), 32'h000C);
        check("ldi_bsel", 32'(bus.BSEL), 32'h1);
        check("ldi_fs", 32'(bus.FS), 32'h08);
        check("ldi_wr", 32'(bus.WR), 32'h1);
        check("ldi_da", 32'(bus.DA), 32'h4);
        tick();
        check("ldi_back_fetch", 32'(bus.NS), 32'h1);

        // LD 6350: four cycles
        bus.IR_OUT = 16'h6350;
        tick();
        check("ld_decode_ns", 32'(bus.NS), 32'h2);
        tick();
        check("ld_mem1_ns", 32'(bus.NS), 32'h4);
        check("ld_mem1_mr", 32'(bus.MR), 32'h1);
        check("ld_mem1_wr", 32'(bus.WR), 32'h0);
        check("ld_mem1_mw", 32'(bus.MW), 32'h0);
        check("ld_mem1_enaddr_alu", 32'(bus.ENADDRESS_ALU), 32'h1);
        check("ld_mem1_sa", 32'(bus.SA), 32'h5);
        tick();
        check("ld_mem2_ns", 32'(bus.NS), 32'h5);
        check("ld_mem2_mr", 32'(bus.MR), 32'h1);
        check("ld_mem2_wr", 32'(bus.WR), 32'h1);
        check("ld_mem2_da", 32'(bus.DA), 32'h3);
        check("ld_mem2_ps", 32'(bus.PS), 32'h1);
        tick();
        check("ld_back_fetch", 32'(bus.NS), 32'h1);

        // ST 7056: three cycles, one MW pulse
        bus.IR_OUT = 16'h7056;
        tick();
        check("st_decode_mw", 32'(bus.MW), 32'h0);
        check("st_decode_wr", 32'(bus.WR), 32'h0);
        tick();
        check("st_mem1_ns", 32'(bus.NS), 32'h4);
        check("st_mem1_mw", 32'(bus.MW), 32'h1);
        check("st_mem1_wr", 32'(bus.WR), 32'h0);
        check("st_mem1_mr", 32'(bus.MR), 32'h0);
        check("st_mem1_sb", 32'(bus.SB), 32'h6);
        tick();
        check("st_back_fetch", 32'(bus.NS), 32'h1);
        check("st_fetch_mw", 32'(bus.MW), 32'h0);

        // BZ taken
        bus.IR_OUT = 16'h80FC;
        bus.status = 4'b0001;
        tick();
        tick();
        check("bz_taken_ps", 32'(bus.PS), 32'h2);
        check("bz_taken_pcsel", 32'(bus.PCSEL), 32'h1);
        check("bz_taken_k", 32'(bus.K), 32'hFFFC);
        tick();

        // BZ not taken
        bus.status = 4'b0000;
        tick();
        tick();
        check("bz_nt_ps", 32'(bus.PS), 32'h1);
        check("bz_nt_pcsel", 32'(bus.PCSEL), 32'h0);
        check("bz_nt_k", 32'(bus.K), 32'h0);
        tick();

        // BNZ taken with Z clear
        bus.IR_OUT = 16'h9010;
        tick();
        tick();
        check("bnz_taken_ps", 32'(bus.PS), 32'h2);
        check("bnz_taken_k", 32'(bus.K), 32'h0010);
        tick();

        // JMP
        bus.IR_OUT = 16'hA030;
        tick();
        tick();
        check("jmp_ps", 32'(bus.PS), 32'h3);
        check("jmp_en_alu", 32'(bus.EN_ALU), 32'h1);
        check("jmp_fs", 32'(bus.FS), 32'h00);
        check("jmp_wr", 32'(bus.WR), 32'h0);
        tick();

        // Illegal opcode C
        bus.IR_OUT = 16'hC123;
        tick();
        check("ill_decode_ns", 32'(bus.NS), 32'h2);
        check("ill_pulse", 32'(bus.ILLEGAL), 32'h1);
        check("ill_ps", 32'(bus.PS), 32'h1);
        check("ill_en_pc", 32'(bus.EN_PC), 32'h1);
        tick();
        check("ill_next_fetch", 32'(bus.NS), 32'h1);
        check("ill_cleared", 32'(bus.ILLEGAL), 32'h0);

        // HALT held
        bus.IR_OUT = 16'hF000;
        tick();
        tick();
        check("halt_ns", 32'(bus.NS), 32'h7);
        check("halt_en_pc", 32'(bus.EN_PC), 32'h0);
        check("halt_rom_en", 32'(bus.ROM_EN), 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("halt_hold_%0d", i), 32'(bus.NS), 32'h7);
        end

        @(negedge clock);
        reset = 1'b0;
        #1;
        check("halt_reset_ns", 32'(bus.NS), 32'h0);
        check("halt_reset_dp", 32'(bus.DP_RESET), 32'h1);

        // Reset asserted in MEM1 of ST
        bus.IR_OUT = 16'h7056;
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("st2_fetch_ns", 32'(bus.NS), 32'h1);
        tick();
        tick();
        check("st2_mem1_mw", 32'(bus.MW), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("st2_abort_mw", 32'(bus.MW), 32'h0);
        check("st2_abort_wr", 32'(bus.WR), 32'h0);
        check("st2_abort_ns", 32'(bus.NS), 32'h0);
        check("st2_abort_dp", 32'(bus.DP_RESET), 32'h1);
        tick();
        check("st2_held_ns", 32'(bus.NS), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
